// File: rtl/req_onehot_arbiter_pkg.sv
// Shared definitions for the request arbiter front-end of the 4:2 encoder.
// Contents:
//   NREQ          number of request lines
//   arb_state_e   arbiter state encoding
//   rr_pick_t     result of a round-robin search (index + found flag)
//   rr_pick()     first set bit of cand searching ptr, ptr+1, ... modulo NREQ
package req_onehot_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // Walk the offsets from farthest to nearest so the nearest hit to ptr
    // is the last one written and therefore wins.
    function automatic rr_pick_t rr_pick(input logic [NREQ-1:0] cand,
                                         input logic [1:0]      ptr);
        rr_pick_t   res;
        logic [1:0] idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + k[1:0];
            if (cand[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/req_onehot_arbiter_sync_edge.sv
// req_sync_edge: per-line synchroniser plus rising-edge detector for
// button/strobe style request lines.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          raw (possibly asynchronous) request lines
//   req_s        request lines after SYNC_STAGES flops (0 = pass-through)
//   rise         registered one-cycle pulse per 0->1 transition of req_s
module req_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] req_s,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] req_d_q;
    logic [WIDTH-1:0] rise_q;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign req_s = req;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= req;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign req_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // The edge pulse is registered so the arbiter sees a glitch-free,
    // exactly one-cycle event per held request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d_q <= '0;
            rise_q  <= '0;
        end else begin
            req_d_q <= req_s;
            rise_q  <= req_s & ~req_d_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/req_onehot_arbiter.sv
// req_onehot_arbiter: turns four asynchronous request lines into a held,
// strictly one-hot grant vector for the 4:2 encoder inputs d3..d0.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   request lines, bit i -> encoder input di
//   ack        consumer acknowledge, only honoured in GRANT
//   gnt[3:0]   one-hot grant, zero when idle
//   gnt_valid  high while gnt is non-zero
//   timeout    one-cycle pulse when a grant is dropped by timeout
//
// state | meaning
// IDLE  | no grant; selects from pending | rise when anything is waiting
// GRANT | gnt held; leaves on ack or timer expiry
// GAP   | one forced all-zero cycle so the encoder never sees two bits
module req_onehot_arbiter
    import req_onehot_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int            TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      sel_q, sel_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            timeout_q, timeout_d;

    logic [NREQ-1:0] req_s_unused;
    logic [NREQ-1:0] rise;
    logic [NREQ-1:0] cand;
    rr_pick_t        pick;
    logic            timer_expired;

    req_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (NREQ)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .req_s (req_s_unused),
        .rise  (rise)
    );

    assign cand          = pending_q | rise;
    assign pick          = rr_pick(cand, ptr_q);
    assign timer_expired = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            ptr_q       <= '0;
            sel_q       <= '0;
            timer_q     <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | rise;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    // The winning rise is consumed here; any other
                    // coincident rises stay pending.
                    pending_d   = cand & ~(4'b0001 << pick.idx);
                    gnt_d       = 4'b0001 << pick.idx;
                    gnt_valid_d = 1'b1;
                    sel_d       = pick.idx;
                    timer_d     = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (ack || timer_expired) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = sel_q + 2'd1;
                    timeout_d   = !ack;
                    state_d     = ST_GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        gnt_valid = gnt_valid_q;
        timeout   = timeout_q;
    end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
module tb_req_onehot_arbiter;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_onehot_arbiter #(
        .SYNC_STAGES (2),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Reference model: a request sampled high at edge e-3 that was low at
    // edge e-4 becomes eligible at edge e. Grants are tracked as "who"
    // and "how many cycles visible"; the round-robin start is the line
    // after the last served one.
    bit [3:0] past1, past2, past3, past4;
    bit [3:0] m_pend, m_rise, m_cand, m_gnt;
    bit       m_to, m_found;
    int       m_mode, m_who, m_age, m_ptr, m_idx;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                past1 = 0; past2 = 0; past3 = 0; past4 = 0;
                m_pend = 0; m_gnt = 0; m_to = 0;
                m_mode = 0; m_who = 0; m_age = 0; m_ptr = 0;
            end else begin
                m_rise = past3 & ~past4;
                past4 = past3; past3 = past2; past2 = past1; past1 = req;
                m_to = 0;
                if (m_mode == 0) begin
                    m_cand  = m_pend | m_rise;
                    m_found = 0;
                    for (int j = 0; j < 4; j++) begin
                        m_idx = (m_ptr + j) % 4;
                        if (!m_found && m_cand[m_idx]) begin
                            m_found = 1;
                            m_who   = m_idx;
                        end
                    end
                    if (m_found) begin
                        m_pend = m_cand & ~(4'b0001 << m_who);
                        m_gnt  = 4'b0001 << m_who;
                        m_age  = 1;
                        m_mode = 1;
                    end
                end else if (m_mode == 1) begin
                    m_pend = m_pend | m_rise;
                    if (ack || m_age == TO) begin
                        m_to   = !ack;
                        m_gnt  = 0;
                        m_ptr  = (m_who + 1) % 4;
                        m_mode = 2;
                    end else begin
                        m_age = m_age + 1;
                    end
                end else begin
                    m_pend = m_pend | m_rise;
                    m_mode = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt != 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid: got %b expected 0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    endtask

    task automatic test_single();
        int nz;
        do_reset();
        req = 4'b0100;
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_early: got %b expected 0000 after 3 edges", gnt); end
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_latency: got %b expected 0100 after 4 edges", gnt); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", gnt_valid); end
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_hold: got %b expected 0100", gnt); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin errors++; $display("FAIL single_release: got gnt=%b valid=%b expected 0000/0", gnt, gnt_valid); end
        nz = 0;
        repeat (8) begin @(negedge clk); if (gnt != 4'b0000) nz++; end
        checks++; if (nz != 0) begin errors++; $display("FAIL single_no_regrant: got %0d granted cycles expected 0", nz); end
        req = 4'b0000;
    endtask

    task automatic test_simultaneous();
        bit       ok;
        bit [3:0] exp_seq [3];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000;
        do_reset();
        req = 4'b1011;
        wait_gnt(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_wait: got no grant expected one within 10 cycles"); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (gnt !== exp_seq[k]) begin errors++; $display("FAIL simul_order%0d: got %b expected %b", k, gnt, exp_seq[k]); end
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL simul_gap%0d: got %b expected 0000", k, gnt); end
            @(negedge clk);
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL simul_idle%0d: got %b expected 0000", k, gnt); end
            @(negedge clk);
        end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL simul_done: got %b expected 0000", gnt); end
        req = 4'b0000;
    endtask

    task automatic test_fairness();
        bit       ok;
        bit [3:0] exp_seq [3];
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0010;
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        wait_gnt(10, ok);
        checks++; if (!ok || gnt !== 4'b0010) begin errors++; $display("FAIL fair_first: got %b expected 0010", gnt); end
        req = 4'b1011;
        @(negedge clk);
        req = 4'b0000;
        repeat (6) @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL fair_hold: got %b expected 0010", gnt); end
        for (int k = 0; k < 3; k++) begin
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            repeat (2) @(negedge clk);
            checks++; if (gnt !== exp_seq[k]) begin errors++; $display("FAIL fair_order%0d: got %b expected %b", k, gnt, exp_seq[k]); end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL fair_drained: got %b expected 0000", gnt); end
    endtask

    task automatic test_timeout();
        bit ok, bad_to;
        int n, nz;
        do_reset();
        req = 4'b0001;
        wait_gnt(10, ok);
        checks++; if (!ok || gnt !== 4'b0001) begin errors++; $display("FAIL to_grant: got %b expected 0001", gnt); end
        n = 1; bad_to = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt == 4'b0001) begin
                n++;
                if (timeout) bad_to = 1;
            end else begin
                break;
            end
        end
        checks++; if (n != TO) begin errors++; $display("FAIL to_length: got %0d grant cycles expected %0d", n, TO); end
        checks++; if (bad_to) begin errors++; $display("FAIL to_early_pulse: got pulse during grant expected none"); end
        checks++; if (timeout !== 1'b1 || gnt !== 4'b0000) begin errors++; $display("FAIL to_pulse: got timeout=%b gnt=%b expected 1/0000", timeout, gnt); end
        @(negedge clk);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", timeout); end
        nz = 0;
        repeat (6) begin @(negedge clk); if (gnt != 4'b0000) nz++; end
        checks++; if (nz != 0) begin errors++; $display("FAIL to_no_regrant: got %0d granted cycles expected 0", nz); end
        req = 4'b0000;
    endtask

    task automatic test_ack_at_expiry();
        bit ok;
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        wait_gnt(10, ok);
        repeat (TO - 1) @(negedge clk);
        checks++; if (!ok || gnt !== 4'b0001) begin errors++; $display("FAIL ackexp_hold: got %b expected 0001", gnt); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL ackexp_nopulse: got gnt=%b timeout=%b expected 0000/0", gnt, timeout); end
        @(negedge clk);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL ackexp_late: got %b expected 0", timeout); end
    endtask

    task automatic test_queue();
        bit ok;
        int nz;
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        wait_gnt(10, ok);
        checks++; if (!ok || gnt !== 4'b0001) begin errors++; $display("FAIL queue_first: got %b expected 0001", gnt); end
        req = 4'b0100; @(negedge clk);
        req = 4'b0000; @(negedge clk);
        req = 4'b0001; @(negedge clk);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL queue_hold: got %b expected 0001", gnt); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL queue_pulse2: got %b expected 0100", gnt); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL queue_rerequest0: got %b expected 0001", gnt); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        nz = 0;
        repeat (6) begin @(negedge clk); if (gnt != 4'b0000) nz++; end
        checks++; if (nz != 0) begin errors++; $display("FAIL queue_drained: got %0d granted cycles expected 0", nz); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int nz;
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        wait_gnt(10, ok);
        checks++; if (!ok || gnt !== 4'b1000) begin errors++; $display("FAIL arst_grant: got %b expected 1000", gnt); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL arst_gnt: got %b expected 0000 without clock edge", gnt); end
        checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL arst_flags: got valid=%b timeout=%b expected 0/0", gnt_valid, timeout); end
        #3 rst_n = 1'b1;
        nz = 0;
        repeat (10) begin @(negedge clk); if (gnt != 4'b0000) nz++; end
        checks++; if (nz != 0) begin errors++; $display("FAIL arst_stale: got %0d granted cycles expected 0", nz); end
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        wait_gnt(10, ok);
        checks++; if (!ok || gnt !== 4'b0010) begin errors++; $display("FAIL arst_fresh: got %b expected 0010", gnt); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
    endtask

    task automatic test_random();
        int ack_div;
        bit [3:0] mask;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++; if (gnt !== m_gnt) begin errors++; $display("FAIL rand_gnt cycle %0d: got %b expected %b", c, gnt, m_gnt); end
            checks++; if (gnt_valid !== (m_gnt != 4'b0000)) begin errors++; $display("FAIL rand_valid cycle %0d: got %b expected %b", c, gnt_valid, m_gnt != 4'b0000); end
            checks++; if (timeout !== m_to) begin errors++; $display("FAIL rand_timeout cycle %0d: got %b expected %b", c, timeout, m_to); end
            checks++; if ($countones(gnt) > 1) begin errors++; $display("FAIL rand_onehot cycle %0d: got %b expected at most one bit", c, gnt); end
            case ((c / 500) % 3)
                0:       ack_div = 0;
                1:       ack_div = 8;
                default: ack_div = 2;
            endcase
            for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(0, 5) == 0);
            req = req ^ mask;
            ack = (ack_div != 0) && ($urandom_range(0, ack_div - 1) == 0);
        end
        req = 4'b0000;
        ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_ack_at_expiry();
        test_queue();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
